// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle.
module multicycle_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             illegal_op,
   output logic             ready,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_NOT  = 4'h2;
   localparam logic [3:0] OP_SLL  = 4'h3;
   localparam logic [3:0] OP_SRL  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_SLTU = 4'h7;
   localparam logic [3:0] OP_SRA  = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_NOR  = 4'hA;
   localparam logic [3:0] OP_SLT  = 4'hB;
   localparam logic [3:0] OP_MULU = 4'hC;
   localparam logic [3:0] OP_DIVU = 4'hD;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, hi_q, lo_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] res_q, res_hi_q;
   logic             zero_q, ovf_q, dbz_q, ill_q;

   logic [WIDTH-1:0] sum, diff, sc_res;
   logic             sc_ovf, sc_ill;
   logic [WIDTH:0]   mul_sum, div_sh, div_trial;
   logic [WIDTH-1:0] mul_hi_d, mul_lo_d, div_rem_d, div_quo_d;

   always_comb begin
      sum    = input1 + input2;
      diff   = input1 - input2;
      sc_res = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      unique case (alu_op)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                     (sum[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                     (diff[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_NOT:  sc_res = ~input1;
         OP_SLL:  sc_res = input1 << shamt;
         OP_SRL:  sc_res = input1 >> shamt;
         OP_AND:  sc_res = input1 & input2;
         OP_OR:   sc_res = input1 | input2;
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, input1 < input2};
         OP_SRA:  sc_res = $signed(input1) >>> shamt;
         OP_XOR:  sc_res = input1 ^ input2;
         OP_NOR:  sc_res = ~(input1 | input2);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                            $signed(input1) < $signed(input2)};
         default: sc_ill = (alu_op != OP_MULU) && (alu_op != OP_DIVU);
      endcase
   end

   // hi_q/lo_q: product accumulator/multiplier, or remainder/quotient
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      mul_hi_d  = mul_sum[WIDTH:1];
      mul_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
      div_sh    = {hi_q, lo_q[WIDTH-1]};
      div_trial = div_sh - {1'b0, a_q};
      div_rem_d = div_trial[WIDTH] ? div_sh[WIDTH-1:0]
                                   : div_trial[WIDTH-1:0];
      div_quo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  unique case (alu_op)
                     OP_MULU: begin
                        state_q <= MUL;
                        a_q     <= input1;
                        hi_q    <= '0;
                        lo_q    <= input2;
                        cnt_q   <= SHW'(WIDTH-1);
                     end
                     OP_DIVU: begin
                        state_q <= DIV;
                        a_q     <= input2;
                        hi_q    <= '0;
                        lo_q    <= input1;
                        cnt_q   <= SHW'(WIDTH-1);
                     end
                     default: begin
                        state_q  <= DONE;
                        res_q    <= sc_res;
                        res_hi_q <= '0;
                        zero_q   <= (sc_res == '0);
                        ovf_q    <= sc_ovf;
                        dbz_q    <= 1'b0;
                        ill_q    <= sc_ill;
                     end
                  endcase
               end else begin
                  state_q <= IDLE;
               end
            end
            MUL: begin
               hi_q  <= mul_hi_d;
               lo_q  <= mul_lo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q  <= DONE;
                  res_q    <= mul_lo_d;
                  res_hi_q <= mul_hi_d;
                  zero_q   <= (mul_lo_d == '0) && (mul_hi_d == '0);
                  ovf_q    <= 1'b0;
                  dbz_q    <= 1'b0;
                  ill_q    <= 1'b0;
               end
            end
            DIV: begin
               hi_q  <= div_rem_d;
               lo_q  <= div_quo_d;
               cnt_q <= cnt_q - 1'b1;
               // A zero divisor always "subtracts": all-ones quotient,
               // and the dividend shifts through intact as remainder.
               if (cnt_q == '0) begin
                  state_q  <= DONE;
                  res_q    <= div_quo_d;
                  res_hi_q <= div_rem_d;
                  zero_q   <= (div_quo_d == '0) && (div_rem_d == '0);
                  ovf_q    <= 1'b0;
                  dbz_q    <= (a_q == '0);
                  ill_q    <= 1'b0;
               end
            end
         endcase
      end
   end

   assign ready       = (state_q == IDLE) || (state_q == DONE);
   assign done        = (state_q == DONE);
   assign result      = res_q;
   assign result_hi   = res_hi_q;
   assign zero        = zero_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;
   assign illegal_op  = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus
// random ops against an arithmetic reference model.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu_op;
   logic [31:0] input1, input2;
   logic [4:0]  shamt;
   logic [31:0] result, result_hi;
   logic        zero, overflow, div_by_zero, illegal_op, ready, done;

   int nvec = 0;
   int nerr = 0;

   multicycle_alu #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
      .input1(input1), .input2(input2), .shamt(shamt),
      .result(result), .result_hi(result_hi), .zero(zero),
      .overflow(overflow), .div_by_zero(div_by_zero),
      .illegal_op(illegal_op), .ready(ready), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(
      input  logic [3:0]  op,
      input  logic [31:0] a, b,
      input  logic [4:0]  sh,
      output logic [31:0] lo, hi,
      output logic        ovf, dbz, ill,
      output int          lat);
      longint      s;
      int          sa, sb;
      logic [63:0] p;
      logic [31:0] ones;
      ones = '1;
      sa = a;
      sb = b;
      lo = 0; hi = 0; ovf = 0; dbz = 0; ill = 0; lat = 1;
      case (op)
         4'd0: begin
            s = longint'(sa) + longint'(sb);
            lo = a + b;
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            s = longint'(sa) - longint'(sb);
            lo = a - b;
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2:  lo = ~a;
         4'd3:  lo = a << sh;
         4'd4:  lo = a >> sh;
         4'd5:  lo = a & b;
         4'd6:  lo = a | b;
         4'd7:  lo = (a < b) ? 1 : 0;
         4'd8:  lo = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
         4'd9:  lo = a ^ b;
         4'd10: lo = ~(a | b);
         4'd11: lo = (sa < sb) ? 1 : 0;
         4'd12: begin
            p = {32'h0, a} * {32'h0, b};
            lo = p[31:0];
            hi = p[63:32];
            lat = 33;
         end
         4'd13: begin
            lat = 33;
            if (b == 0) begin
               lo = ones; hi = a; dbz = 1;
            end else begin
               lo = a / b; hi = a % b;
            end
         end
         default: ill = 1;
      endcase
   endfunction

   // Issue one op at a negedge with ready=1; optionally pulse an ADD
   // request while busy (poke = cycle index, 0 = none).
   task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input int poke);
      logic [31:0] elo, ehi;
      logic        eovf, edbz, eill;
      int          lat;
      model(op, a, b, sh, elo, ehi, eovf, edbz, eill, lat);
      chk("ready_before", {63'h0, ready}, 64'd1);
      alu_op = op; input1 = a; input2 = b; shamt = sh; start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      input1 = $urandom;
      input2 = $urandom;
      shamt  = 5'($urandom);
      alu_op = 4'($urandom);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk("done", {63'h0, done}, {63'h0, c == lat});
         if (c < lat) chk("busy_ready", {63'h0, ready}, 64'd0);
         if (c == poke) begin
            alu_op = 4'd0; input1 = 32'd1; input2 = 32'd2; start = 1'b1;
         end
      end
      chk("result", {32'h0, result}, {32'h0, elo});
      chk("result_hi", {32'h0, result_hi}, {32'h0, ehi});
      chk("zero", {63'h0, zero}, {63'h0, (elo == 0) && (ehi == 0)});
      chk("overflow", {63'h0, overflow}, {63'h0, eovf});
      chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, edbz});
      chk("illegal_op", {63'h0, illegal_op}, {63'h0, eill});
      chk("ready_done", {63'h0, ready}, 64'd1);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; alu_op = '0;
      input1 = '0; input2 = '0; shamt = '0;
      #2;
      chk("rst_result", {32'h0, result}, 64'd0);
      chk("rst_result_hi", {32'h0, result_hi}, 64'd0);
      chk("rst_flags", {60'h0, zero, overflow, div_by_zero, illegal_op},
          64'd0);
      chk("rst_ready", {63'h0, ready}, 64'd1);
      chk("rst_done", {63'h0, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(4'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0);
      do_op(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 0);
      do_op(4'd13, 32'd100, 32'd7, 5'd0, 0);
      do_op(4'd13, 32'd5, 32'd0, 5'd0, 0);
      do_op(4'd8, 32'h80000000, 32'h0, 5'd4, 0);
      do_op(4'd11, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
      do_op(4'd7, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
      do_op(4'd14, 32'h12345678, 32'h9ABCDEF0, 5'd3, 0);
      @(negedge clk);
      chk("idle_done", {63'h0, done}, 64'd0);

      do_op(4'd0, 32'd10, 32'd20, 5'd0, 0);
      do_op(4'd1, 32'd5, 32'd9, 5'd0, 0);
      do_op(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 0);
      @(negedge clk);
      chk("idle_done2", {63'h0, done}, 64'd0);

      do_op(4'd13, 32'd1000, 32'd3, 5'd0, 5);
      @(negedge clk);
      chk("poke_no_done", {63'h0, done}, 64'd0);

      alu_op = 4'd13; input1 = 32'd1000; input2 = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_result", {32'h0, result}, 64'd0);
      chk("mid_rst_result_hi", {32'h0, result_hi}, 64'd0);
      chk("mid_rst_flags",
          {60'h0, zero, overflow, div_by_zero, illegal_op}, 64'd0);
      chk("mid_rst_ready", {63'h0, ready}, 64'd1);
      chk("mid_rst_done", {63'h0, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", {63'h0, done}, 64'd0);
         chk("post_rst_ready", {63'h0, ready}, 64'd1);
      end

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
         do_op(rop, ra, rb, 5'($urandom), 0);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
